// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture slice: frame geometry, FSM state
// encoding and the RGB565 -> RGB332 pixel packing.
package cam_pkg;

  localparam int unsigned CAM_H_PIX = 160;
  localparam int unsigned CAM_V_PIX = 120;
  localparam int unsigned CAM_NPIX  = CAM_H_PIX * CAM_V_PIX;

  typedef logic [2:0] cam_state_t;

  localparam cam_state_t ST_IDLE       = 3'd0;
  localparam cam_state_t ST_WAIT_FRAME = 3'd1;
  localparam cam_state_t ST_BYTE_HI    = 3'd2;
  localparam cam_state_t ST_BYTE_LO    = 3'd3;
  localparam cam_state_t ST_DONE       = 3'd4;

  // Keep the top 3 bits of red and green and the top 2 bits of blue.
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi,
                                                  input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_pix_pack.sv
// Pixel assembly for cam_capture: latches the RGB565 high byte and registers
// the packed RGB332 pixel together with its one-cycle write strobe.
module cam_pix_pack
  import cam_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_hi_en,
  input  logic          i_lo_en,
  input  logic [7:0]    i_cam_data,
  output logic [DW-1:0] o_data,
  output logic          o_we
);

  logic [7:0]    r_hi;
  logic [DW-1:0] r_data;
  logic          r_we;
  logic [7:0]    w_packed;

  assign w_packed = rgb565_to_rgb332(r_hi, i_cam_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi   <= '0;
      r_data <= '0;
      r_we   <= 1'b0;
    end else begin
      r_we <= i_lo_en;
      if (i_hi_en) r_hi <= i_cam_data;
      if (i_lo_en) r_data <= DW'(w_packed);
    end
  end

  assign o_data = r_data;
  assign o_we   = r_we;

endmodule

// File: rtl/cam_capture.sv
// Camera-to-frame-buffer capture: assembles RGB565 byte pairs into RGB332
// writes. Define CAM_CAPTURE_CONT_EN for continuous (free-running) capture.
module cam_capture
  import cam_pkg::*;
#(
  parameter int AW   = 15,
  parameter int DW   = 8,
  parameter int NPIX = CAM_NPIX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    cam_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  cam_state_t    r_state;
  cam_state_t    w_state_nxt;
  logic          r_vsync_d;
  logic [AW-1:0] r_addr;
  logic          w_hi_en;
  logic          w_lo_en;
  logic          w_we;
  logic [DW-1:0] w_data;

  // vsync high inside a pixel phase ends the frame before any partial write.
  always_comb begin
    w_state_nxt = r_state;
    w_hi_en     = 1'b0;
    w_lo_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (init) w_state_nxt = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (r_vsync_d && !vsync) w_state_nxt = ST_BYTE_HI;
      end
      ST_BYTE_HI: begin
        if (vsync) begin
          w_state_nxt = ST_DONE;
        end else if (href) begin
          w_hi_en     = 1'b1;
          w_state_nxt = ST_BYTE_LO;
        end
      end
      ST_BYTE_LO: begin
        if (vsync) begin
          w_state_nxt = ST_DONE;
        end else if (href) begin
          w_lo_en     = 1'b1;
          w_state_nxt = (r_addr == LAST_ADDR) ? ST_DONE : ST_BYTE_HI;
        end else begin
          w_state_nxt = ST_BYTE_HI;
        end
      end
      ST_DONE: begin
`ifdef CAM_CAPTURE_CONT_EN
        w_state_nxt = ST_WAIT_FRAME;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The address advances after each strobe; DONE rewinds it for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_vsync_d <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_vsync_d <= vsync;
      if (r_state == ST_DONE) r_addr <= '0;
      else if (w_we)          r_addr <= r_addr + AW'(1);
    end
  end

  cam_pix_pack #(
    .DW(DW)
  ) u_pix_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_hi_en   (w_hi_en),
    .i_lo_en   (w_lo_en),
    .i_cam_data(cam_data),
    .o_data    (w_data),
    .o_we      (w_we)
  );

  assign addr_in    = r_addr;
  assign data_in    = w_data;
  assign regwrite   = w_we;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter AW, default 15, SHALL set the frame-buffer address width.
REQ-002 Parameter DW, default 8, SHALL set the frame-buffer pixel width (RGB332).
REQ-003 Parameter NPIX, default 19200, SHALL set the pixels per frame (160x120).
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; the camera pixel clock drives it. All logic is on its rising edge.
REQ-005 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-006 Port init, input, 1 bit, SHALL be the start-capture request, sampled high for one cycle.
REQ-007 Port vsync, input, 1 bit, SHALL be the camera frame sync; high means vertical blanking.
REQ-008 Port href, input, 1 bit, SHALL be the camera line-valid signal.
REQ-009 Port cam_data, input, 8 bits, SHALL be the camera byte bus (RGB565, two bytes per pixel, high byte first).
REQ-010 Port addr_in, output, AW bits, SHALL be the frame-buffer write address.
REQ-011 Port data_in, output, DW bits, SHALL be the frame-buffer write pixel.
REQ-012 Port regwrite, output, 1 bit, SHALL be the frame-buffer write strobe.
REQ-013 Port busy, output, 1 bit, SHALL be high in every state except IDLE.
REQ-014 Port frame_done, output, 1 bit, SHALL pulse high for exactly one cycle when a frame completes.

Function
REQ-015 The state machine SHALL have exactly these states: IDLE, WAIT_FRAME, BYTE_HI, BYTE_LO, DONE.
REQ-016 IDLE SHALL go to WAIT_FRAME when init=1.
REQ-017 WAIT_FRAME SHALL go to BYTE_HI on the first cycle vsync=0 after vsync was 1 (vsync falling edge, registered).
REQ-018 In BYTE_HI with href=1, the block SHALL latch cam_data as the high byte and go to BYTE_LO.
REQ-019 In BYTE_HI with href=0, the block SHALL stay in BYTE_HI.
REQ-020 In BYTE_LO with href=1, the block SHALL register data_in = {hi[7:5], hi[2:0], cam_data[4:3]}, pulse regwrite for one cycle, and go to BYTE_HI.
REQ-021 regwrite latency SHALL be exactly one cycle after the low byte is sampled; addr_in SHALL be stable in the cycle regwrite is high.
REQ-022 addr_in SHALL start at 0 for each frame and increment by 1 in the cycle after each regwrite.
REQ-023 When the write at address NPIX-1 completes, the block SHALL enter DONE; it SHALL NOT write beyond NPIX-1, and bytes after that point are ignored.
REQ-024 If href falls while in BYTE_LO, the block SHALL discard the half pixel, return to BYTE_HI, and leave addr_in unchanged.
REQ-025 If vsync rises during BYTE_HI or BYTE_LO before NPIX pixels are written (short frame), the block SHALL enter DONE; no write of the partial pixel occurs.
REQ-026 DONE SHALL pulse frame_done for one cycle and go to IDLE; the CAM_CAPTURE_CONT_EN behaviour is given in REQ-031.
REQ-027 An init pulse outside IDLE SHALL be ignored.

Reset
REQ-028 On rst_n=0, the block SHALL go asynchronously to IDLE with addr_in=0, data_in=0, regwrite=0, busy=0, frame_done=0, the high-byte latch at 0, and the vsync history at 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with no further regwrite pulses.
REQ-030 After reset release, the block SHALL stay in IDLE until init=1.

Configuration
REQ-031 Macro CAM_CAPTURE_CONT_EN: when defined, DONE SHALL go to WAIT_FRAME instead of IDLE, giving continuous capture; init is needed only for the first frame and busy stays high.
REQ-032 When CAM_CAPTURE_CONT_EN is undefined, capture SHALL be single-shot per REQ-026.

Structure
REQ-033 Package cam_pkg SHALL hold the state encoding typedef, the frame constants (160, 120, NPIX), and the RGB565-to-RGB332 packing function.
REQ-034 The design SHALL have one sub-module, cam_pix_pack, holding the high-byte latch, the packing, and the data_in/regwrite registers; the FSM and address counter stay in cam_capture.

Verification
REQ-035 Reset, init pulse, vsync 1->0, then 1 pixel with bytes 0xF8, 0x1F -> one regwrite with addr_in=0, data_in=0xE3.
REQ-036 Full frame of 19200 pixels, each bytes 0xFF, 0xFF -> 19200 regwrite pulses, addresses 0..19199 all written with 0xFF, a single frame_done pulse, then busy=0.
REQ-037 href drops after the high byte 0x07, then the pixel 0x00, 0x18 follows -> one write, data_in=0x03, addr_in=0.
REQ-038 vsync rises after 100 pixels -> last write at addr_in=99, frame_done pulses, state returns to IDLE.
REQ-039 rst_n asserted at pixel 500 -> regwrite=0 and addr_in=0 in the same cycle; a later init restarts from address 0.
REQ-040 With CAM_CAPTURE_CONT_EN defined, two back-to-back frames on a single init -> two frame_done pulses, addr_in restarts at 0 for each frame, busy stays 1.
